if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of ID. Owns the word-addressed PC, fetches from a
//  variable-latency instruction memory (one request outstanding), and drives the IF/ID pipeline
//  register: IF_ID_Ins, IF_ID_PC_P1 (=PC+1). Takes redirects (ID_PCSrc/ID_PCBranch) from ID and
//  stalls from the hazard unit.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first word address fetched after reset
//  NOP_INS   32'h0000_0000  bubble instruction loaded into IF/ID on flush
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  ID_PCSrc     in   1   redirect request from ID (taken branch, j, jr)
//  ID_PCBranch  in   32  redirect target, word address
//  Stall        in   1   hazard unit: hold IF/ID contents and PC
//  imem_req     out  1   fetch request, registered
//  imem_addr    out  32  word address; stable while imem_req=1 and no imem_rvalid yet
//  imem_rvalid  in   1   response valid, >=1 cycle after imem_req rises or after the previous
//                        response
//  imem_rdata   in   32  instruction, valid with imem_rvalid
//  IF_ID_Ins    out  32  instruction to ID
//  IF_ID_PC_P1  out  32  PC+1 of that instruction
//  IF_ID_Valid  out  1   0 = bubble
// BEHAVIOUR
//  - Reset: PC=RESET_PC, imem_req=0, IF_ID_Ins=NOP_INS, IF_ID_PC_P1=0, IF_ID_Valid=0, hold
//    buffer empty, state=IDLE. Deassertion is synchronised by the design's reset tree.
//  - States:
//    - IDLE: one cycle; then FETCH with imem_req=1.
//    - FETCH: waiting on imem_rvalid.
//    - HOLD: response buffered while Stall=1.
//    - KILL: an outstanding response must be discarded.
//  - Redirect is valid only when ID_PCSrc=1 && Stall=0. ID_PCSrc is ignored while Stall=1.
//  - FETCH, rvalid, no redirect, Stall=0:
//    - IF/ID <= {rdata, PC+1, valid=1}; PC <= PC+1.
//    - New request issued on the next cycle. Throughput is 1 instr per (mem latency+1) cycles.
//  - FETCH, rvalid, Stall=1: rdata -> hold buffer, go to HOLD. imem_req=0 while in HOLD.
//  - HOLD, Stall=0: buffer -> IF/ID, PC <= PC+1, go to FETCH.
//  - Redirect without IF_DELAY_SLOT_EN:
//    - IF/ID <= {NOP_INS, 0, 0}; PC <= ID_PCBranch.
//    - FETCH without rvalid: go to KILL. Await rvalid, drop the data, then FETCH at the target.
//    - FETCH with rvalid in the same cycle: drop the data, go to FETCH at the target.
//    - HOLD: drop the buffer, go to FETCH.
//  - Simultaneous redirect and Stall: Stall wins. Nothing moves and the redirect is not latched.
//  - Redirect during KILL is impossible (IF/ID holds a bubble). If ID_PCSrc=1 anyway, PC takes
//    the new target and the FSM stays in KILL.
//  - PC+1 is 32-bit wrap-around (32'hFFFF_FFFF -> 0).
//  - imem_addr always equals the PC register.
//  - Reset asserted mid-fetch abandons the request. Any later stale rvalid while in IDLE is
//    ignored.
// CONFIGURATION
//  IF_DELAY_SLOT_EN defined:
//    - The instruction after a branch (the delay slot) is delivered to ID, not flushed.
//    - On redirect the target is stored in pend_tgt with pend_vld=1.
//    - The in-flight or held delay-slot instruction enters IF/ID normally. Then PC <= pend_tgt
//      (not PC+1) and pend_vld clears.
//    - No KILL state is used.
//  IF_DELAY_SLOT_EN undefined: flush behaviour as above; pend_tgt/pend_vld are not built.
// STRUCTURE
//  - Shared package if_pkg:
//    - state enum {IDLE, FETCH, HOLD, KILL};
//    - NOP_INS default;
//    - RESET_PC default;
//    - IF/ID bundle struct {ins, pc_p1, valid}.
//  - One sub-module, if_pc_unit: PC register, +1 adder, next-PC mux
//    (PC+1 / ID_PCBranch / pend_tgt) with async reset.
//  - FSM, hold buffer and IF/ID register stay in the top.
// TESTING
//  1. Reset release, mem latency 1, Stall=0.
//     -> imem_addr 0,1,2...; IF_ID_PC_P1 1,2,3 every 2 cycles; Valid=1.
//  2. Latency 3, Stall=1 for 4 cycles while rvalid fires with 32'h2108_0001.
//     -> IF/ID unchanged during Stall; 32'h2108_0001 appears the cycle after Stall drops.
//  3. Flush, macro off. ID_PCSrc=1, ID_PCBranch=32'h40, fetch outstanding.
//     -> IF_ID_Valid=0; next rvalid dropped; next imem_addr=32'h40.
//  4. Delay slot, macro on, same stimulus.
//     -> in-flight word reaches IF/ID with Valid=1, then imem_addr=32'h40.
//  5. ID_PCSrc=1 together with Stall=1 for 2 cycles, then both 0.
//     -> no redirect; PC continues PC+1.
//  6. rst_n pulsed low while imem_req=1 with response pending.
//     -> all outputs at reset values immediately; stale rvalid ignored; refetch from RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INS_DEF  = 32'h0000_0000;

    // Fetch controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } state_e;

    // Next-PC source select
    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_PEND   = 2'd2
    } pc_sel_e;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] ins;
        logic [XLEN-1:0] pc_p1;
        logic            valid;
    } ifid_t;

    // Bubble loaded into IF/ID on flush and reset
    function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop);
        ifid_t b;
        b.ins   = nop;
        b.pc_p1 = '0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus, one request outstanding.
interface if_fetch_stage_if;
    import if_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_pc_unit.sv
// Program counter: register, +1 incrementer (wraps at 32 bits) and next-PC mux.
module if_pc_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  pc_sel_e         i_sel,
    input  logic [XLEN-1:0] i_branch,
    input  logic [XLEN-1:0] i_pend_tgt,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_p1_c
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    assign o_pc      = r_pc;
    assign o_pc_p1_c = r_pc + XLEN'(1);

    // Select the next PC source
    always_comb begin
        w_pc_next = o_pc_p1_c;
        case (i_sel)
            PC_BRANCH: w_pc_next = i_branch;
            PC_PEND:   w_pc_next = i_pend_tgt;
            default:   w_pc_next = o_pc_p1_c;
        endcase
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= w_pc_next;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem fetch, IF/ID register.
// Optional feature macro: IF_DELAY_SLOT_EN (deliver the branch delay slot instead of flushing).
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INS  = NOP_INS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ID_PCSrc,
    input  logic [XLEN-1:0]     ID_PCBranch,
    input  logic                Stall,
    if_fetch_stage_if.master    imem,
    output logic [XLEN-1:0]     IF_ID_Ins,
    output logic [XLEN-1:0]     IF_ID_PC_P1,
    output logic                IF_ID_Valid
);

    state_e          r_state;
    state_e          w_state_n;
    logic            r_req;
    logic            w_req_n;
    logic [XLEN-1:0] r_hold_buf;
    ifid_t           r_ifid;

    logic            w_redirect;
    logic            w_flush;
    logic            w_deliver;
    logic            w_from_buf;
    logic            w_buf_load;
    logic            w_pc_load;
    pc_sel_e         w_pc_sel;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_p1;
    logic [XLEN-1:0] w_pend_tgt;

`ifdef IF_DELAY_SLOT_EN
    logic            r_pend_vld;
    logic [XLEN-1:0] r_pend_tgt;
    logic            w_pend_set;
`endif

    // Stall outranks a redirect; the redirect is simply not seen that cycle
    assign w_redirect = ID_PCSrc && !Stall;

    if_pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_pc_load),
        .i_sel      (w_pc_sel),
        .i_branch   (ID_PCBranch),
        .i_pend_tgt (w_pend_tgt),
        .o_pc       (w_pc),
        .o_pc_p1_c  (w_pc_p1)
    );

    // Next-state, PC control and IF/ID control decode
    always_comb begin
        w_state_n  = r_state;
        w_req_n    = r_req;
        w_flush    = 1'b0;
        w_deliver  = 1'b0;
        w_from_buf = 1'b0;
        w_buf_load = 1'b0;
        w_pc_load  = 1'b0;
        w_pc_sel   = PC_INC;
`ifdef IF_DELAY_SLOT_EN
        w_pend_set = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_state_n = FETCH;
                w_req_n   = 1'b1;
                if (w_redirect) begin
`ifdef IF_DELAY_SLOT_EN
                    w_pend_set = 1'b1;
`else
                    w_flush   = 1'b1;
                    w_pc_load = 1'b1;
                    w_pc_sel  = PC_BRANCH;
`endif
                end
            end
            FETCH: begin
                if (imem.imem_rvalid && Stall) begin
                    w_buf_load = 1'b1;
                    w_state_n  = HOLD;
                    w_req_n    = 1'b0;
                end else if (imem.imem_rvalid) begin
`ifdef IF_DELAY_SLOT_EN
                    w_deliver = 1'b1;
`else
                    if (w_redirect) begin
                        w_flush   = 1'b1;
                        w_pc_load = 1'b1;
                        w_pc_sel  = PC_BRANCH;
                    end else begin
                        w_deliver = 1'b1;
                    end
`endif
                end else if (w_redirect) begin
`ifdef IF_DELAY_SLOT_EN
                    w_pend_set = 1'b1;
`else
                    w_flush   = 1'b1;
                    w_pc_load = 1'b1;
                    w_pc_sel  = PC_BRANCH;
                    w_state_n = KILL;
                    w_req_n   = 1'b0;
`endif
                end
            end
            HOLD: begin
                if (!Stall) begin
                    w_state_n = FETCH;
                    w_req_n   = 1'b1;
`ifdef IF_DELAY_SLOT_EN
                    w_deliver  = 1'b1;
                    w_from_buf = 1'b1;
`else
                    if (w_redirect) begin
                        w_flush   = 1'b1;
                        w_pc_load = 1'b1;
                        w_pc_sel  = PC_BRANCH;
                    end else begin
                        w_deliver  = 1'b1;
                        w_from_buf = 1'b1;
                    end
`endif
                end
            end
            KILL: begin
                if (w_redirect) begin
                    w_flush   = 1'b1;
                    w_pc_load = 1'b1;
                    w_pc_sel  = PC_BRANCH;
                end
                if (imem.imem_rvalid) begin
                    w_state_n = FETCH;
                    w_req_n   = 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_req_n   = 1'b0;
            end
        endcase

        // A delivered instruction advances the PC (to the branch target after a delay slot)
        if (w_deliver) begin
            w_pc_load = 1'b1;
`ifdef IF_DELAY_SLOT_EN
            if (w_redirect) begin
                w_pc_sel = PC_BRANCH;
            end else if (r_pend_vld) begin
                w_pc_sel = PC_PEND;
            end else begin
                w_pc_sel = PC_INC;
            end
`else
            w_pc_sel = PC_INC;
`endif
        end
    end

    // State, request, hold buffer and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_hold_buf <= '0;
            r_ifid     <= ifid_bubble(NOP_INS);
        end else begin
            r_state <= w_state_n;
            r_req   <= w_req_n;
            if (w_buf_load) begin
                r_hold_buf <= imem.imem_rdata;
            end
            if (w_flush) begin
                r_ifid <= ifid_bubble(NOP_INS);
            end else if (w_deliver) begin
                r_ifid.ins   <= w_from_buf ? r_hold_buf : imem.imem_rdata;
                r_ifid.pc_p1 <= w_pc_p1;
                r_ifid.valid <= 1'b1;
            end
        end
    end

`ifdef IF_DELAY_SLOT_EN
    // Branch target parked until the delay-slot instruction has been delivered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend_tgt <= '0;
        end else if (w_pend_set) begin
            r_pend_vld <= 1'b1;
            r_pend_tgt <= ID_PCBranch;
        end else if (w_deliver) begin
            r_pend_vld <= 1'b0;
        end
    end

    assign w_pend_tgt = r_pend_tgt;
`else
    assign w_pend_tgt = '0;
`endif

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = w_pc;
    assign IF_ID_Ins      = r_ifid.ins;
    assign IF_ID_PC_P1    = r_ifid.pc_p1;
    assign IF_ID_Valid    = r_ifid.valid;

endmodule
